// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch control block.
// The state encoding is visible on the state port, so it is fixed explicitly.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } sw_state_t;

    localparam int unsigned TICK_DIV_DEFAULT    = 500000;
    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

    // Time advances in RUN and in LAP; LAP only freezes the display.
    function automatic logic is_counting(input sw_state_t s);
        return (s == RUN) || (s == LAP);
    endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Signals between the stopwatch controller and its counter/display datapath.
// The master side is the controller.
interface stopwatch_if;
    import stopwatch_pkg::*;

    logic      btn_ss;
    logic      btn_lr;
    logic      cnt_max;
    logic      tick;
    logic      cnt_en;
    logic      cnt_clr;
    logic      disp_hold;
    logic      running;
    sw_state_t state;

    modport master (
        input  btn_ss, btn_lr, cnt_max,
        output tick, cnt_en, cnt_clr, disp_hold, running, state
    );

    modport slave (
        output btn_ss, btn_lr, cnt_max,
        input  tick, cnt_en, cnt_clr, disp_hold, running, state
    );

endinterface

// File: rtl/stopwatch_btn_pulse.sv
// Synchronizes an asynchronous, debounced button level into the clk domain
// and emits a one-cycle pulse on each rising level.
module btn_pulse #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear sequencer for the stopwatch counter chain: generates the
// centisecond enable, synchronous clear and display-freeze strobe.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV    = TICK_DIV_DEFAULT,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    stopwatch_if.master   sw
);

    localparam int unsigned    PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic            ss_pulse;
    logic            lr_pulse;
    sw_state_t       state_q, state_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic            clr_d;
    logic            cnt_clr_q;
    logic            disp_hold_q;
    logic            tick;

    btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_ss (
        .clk   (clk),
        .reset (reset),
        .btn   (sw.btn_ss),
        .pulse (ss_pulse)
    );

    btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_lr (
        .clk   (clk),
        .reset (reset),
        .btn   (sw.btn_lr),
        .pulse (lr_pulse)
    );

    // Tick depends on the current state only, so it still fires on a transition cycle.
    assign tick = is_counting(state_q) && (pre_q == PRE_LAST);

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_pulse)      state_d = RUN;
                else if (lr_pulse) clr_d   = 1'b1;
            end
            RUN: begin
                if (tick && sw.cnt_max) state_d = PAUSE;
                else if (ss_pulse)      state_d = PAUSE;
                else if (lr_pulse)      state_d = LAP;
            end
            LAP: begin
                if (tick && sw.cnt_max) state_d = PAUSE;
                else if (ss_pulse)      state_d = PAUSE;
                else if (lr_pulse)      state_d = RUN;
            end
            PAUSE: begin
                // A start press swallows a simultaneous lap/reset press even when saturated.
                if (ss_pulse) begin
                    if (!sw.cnt_max) state_d = RUN;
                end else if (lr_pulse) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Prescaler holds through PAUSE so a resume keeps the fractional centisecond.
    always_comb begin
        pre_d = pre_q;
        if (state_d == IDLE) begin
            pre_d = '0;
        end else if (is_counting(state_q)) begin
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pre_q       <= '0;
            cnt_clr_q   <= 1'b0;
            disp_hold_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            cnt_clr_q   <= clr_d;
            disp_hold_q <= (state_d == LAP);
        end
    end

    assign sw.tick      = tick;
    assign sw.cnt_en    = tick & ~sw.cnt_max;
    assign sw.cnt_clr   = cnt_clr_q;
    assign sw.disp_hold = disp_hold_q;
    assign sw.running   = is_counting(state_q);
    assign sw.state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, SYNC_STAGES=2; expected
// values are hand-derived cycle by cycle from the button-to-state latency.
module tb_stopwatch_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    stopwatch_if sw_if ();

    stopwatch_ctrl #(
        .TICK_DIV    (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"},     int'(sw_if.state),     0);
        check({tag, "_tick"},      int'(sw_if.tick),      0);
        check({tag, "_cnt_en"},    int'(sw_if.cnt_en),    0);
        check({tag, "_cnt_clr"},   int'(sw_if.cnt_clr),   0);
        check({tag, "_disp_hold"}, int'(sw_if.disp_hold), 0);
        check({tag, "_running"},   int'(sw_if.running),   0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset          = 1'b0;
        sw_if.btn_ss   = 1'b0;
        sw_if.btn_lr   = 1'b0;
        sw_if.cnt_max  = 1'b0;

        #12;
        check_all_zero("rst");
        #6;
        reset = 1'b1;
        step(2);
        check("post_rst_state", int'(sw_if.state), 0);
        check("post_rst_clr",   int'(sw_if.cnt_clr), 0);

        // 1. Start; enable on RUN cycles 4, 8, 12; held button is inert.
        sw_if.btn_ss = 1'b1;
        step(2);
        check("s1_before", int'(sw_if.state), 0);
        step(1);
        check("s1_run", int'(sw_if.state), 1);
        check("s1_running", int'(sw_if.running), 1);
        for (int c = 1; c <= 12; c++) begin
            check($sformatf("s1_cnt_en_c%0d", c), int'(sw_if.cnt_en), (c % 4 == 0) ? 1 : 0);
            check($sformatf("s1_tick_c%0d", c), int'(sw_if.tick), (c % 4 == 0) ? 1 : 0);
            step(1);
        end
        step(5);
        check("s1_held", int'(sw_if.state), 1);
        sw_if.btn_ss = 1'b0;

        // 2. Pause when prescaler=1, hold 2, resume with tick on 2nd RUN cycle.
        step(6);
        sw_if.btn_ss = 1'b1;
        step(3);
        check("s2_pause", int'(sw_if.state), 2);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("s2_tick_%0d", i), int'(sw_if.tick), 0);
            check($sformatf("s2_cnt_en_%0d", i), int'(sw_if.cnt_en), 0);
            step(1);
        end
        check("s2_still_pause", int'(sw_if.state), 2);
        sw_if.btn_ss = 1'b0;
        step(4);
        sw_if.btn_ss = 1'b1;
        step(2);
        check("s2_before_resume", int'(sw_if.state), 2);
        step(1);
        check("s2_resume", int'(sw_if.state), 1);
        check("s2_r1_tick", int'(sw_if.tick), 0);
        step(1);
        check("s2_r2_tick", int'(sw_if.tick), 1);
        check("s2_r2_cnt_en", int'(sw_if.cnt_en), 1);
        sw_if.btn_ss = 1'b0;

        // 3. Lap view keeps counting; second lap press returns to RUN.
        step(1);
        sw_if.btn_lr = 1'b1;
        step(3);
        check("s3_lap", int'(sw_if.state), 3);
        check("s3_hold", int'(sw_if.disp_hold), 1);
        check("s3_running", int'(sw_if.running), 1);
        sw_if.btn_lr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("s3_cnt_en_%0d", i), int'(sw_if.cnt_en), (i % 4 == 0) ? 1 : 0);
            step(1);
        end
        sw_if.btn_lr = 1'b1;
        step(2);
        check("s3_still_lap", int'(sw_if.state), 3);
        step(1);
        check("s3_back_run", int'(sw_if.state), 1);
        check("s3_unhold", int'(sw_if.disp_hold), 0);
        sw_if.btn_lr = 1'b0;

        // 4. Clear from PAUSE, then clear again from IDLE.
        sw_if.btn_ss = 1'b1;
        step(3);
        check("s4_pause", int'(sw_if.state), 2);
        sw_if.btn_ss = 1'b0;
        sw_if.btn_lr = 1'b1;
        step(2);
        check("s4_clr_early", int'(sw_if.cnt_clr), 0);
        step(1);
        check("s4_idle", int'(sw_if.state), 0);
        check("s4_clr", int'(sw_if.cnt_clr), 1);
        step(1);
        check("s4_clr_once", int'(sw_if.cnt_clr), 0);
        sw_if.btn_lr = 1'b0;
        step(3);
        sw_if.btn_lr = 1'b1;
        step(3);
        check("s4_idle2", int'(sw_if.state), 0);
        check("s4_clr2", int'(sw_if.cnt_clr), 1);
        step(1);
        check("s4_clr2_once", int'(sw_if.cnt_clr), 0);
        sw_if.btn_lr = 1'b0;

        // Restart: prescaler must have been zeroed, so first enable is on cycle 4.
        sw_if.btn_ss = 1'b1;
        step(3);
        check("s4_restart", int'(sw_if.state), 1);
        sw_if.btn_ss = 1'b0;
        step(2);
        check("s4_c3_cnt_en", int'(sw_if.cnt_en), 0);
        step(1);
        check("s4_c4_cnt_en", int'(sw_if.cnt_en), 1);

        // 5a. Saturation: tick with cnt_max gives no enable and pauses.
        step(1);
        sw_if.cnt_max = 1'b1;
        step(3);
        check("s5_tick", int'(sw_if.tick), 1);
        check("s5_cnt_en", int'(sw_if.cnt_en), 0);
        check("s5_run", int'(sw_if.state), 1);
        step(1);
        check("s5_pause", int'(sw_if.state), 2);
        check("s5_not_running", int'(sw_if.running), 0);
        sw_if.btn_ss = 1'b1;
        step(3);
        check("s5_ss_ignored", int'(sw_if.state), 2);
        step(3);
        check("s5_ss_ignored2", int'(sw_if.state), 2);
        sw_if.btn_ss  = 1'b0;
        sw_if.cnt_max = 1'b0;

        // 5b. ss and lr together in LAP: ss wins.
        step(4);
        sw_if.btn_ss = 1'b1;
        step(3);
        check("s5_resume", int'(sw_if.state), 1);
        sw_if.btn_ss = 1'b0;
        step(1);
        sw_if.btn_lr = 1'b1;
        step(3);
        check("s5_lap", int'(sw_if.state), 3);
        check("s5_lap_hold", int'(sw_if.disp_hold), 1);
        sw_if.btn_lr = 1'b0;
        step(4);
        sw_if.btn_ss = 1'b1;
        sw_if.btn_lr = 1'b1;
        step(3);
        check("s5_both_pause", int'(sw_if.state), 2);
        check("s5_both_hold", int'(sw_if.disp_hold), 0);
        check("s5_both_noclr", int'(sw_if.cnt_clr), 0);
        sw_if.btn_ss = 1'b0;
        sw_if.btn_lr = 1'b0;

        // 6. Asynchronous reset mid-RUN, then a clean start.
        step(4);
        sw_if.btn_ss = 1'b1;
        step(3);
        check("s6_run", int'(sw_if.state), 1);
        sw_if.btn_ss = 1'b0;
        step(5);
        check("s6_running", int'(sw_if.running), 1);
        #3;
        reset = 1'b0;
        #1;
        check_all_zero("s6_async");
        #10;
        reset = 1'b1;
        step(1);
        check("s6_rel_state", int'(sw_if.state), 0);
        check("s6_rel_clr", int'(sw_if.cnt_clr), 0);
        sw_if.btn_ss = 1'b1;
        step(2);
        check("s6_before", int'(sw_if.state), 0);
        step(1);
        check("s6_start", int'(sw_if.state), 1);
        step(2);
        check("s6_c3_cnt_en", int'(sw_if.cnt_en), 0);
        step(1);
        check("s6_c4_cnt_en", int'(sw_if.cnt_en), 1);
        sw_if.btn_ss = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
